// File: rtl/dest_word_packer_pkg.sv
// Shared defaults and width helpers for the dest-domain word packer.
// Widths derive from the module parameters via the helpers below.
package dest_word_packer_pkg;

  localparam int DATAWIDTH_DEF      = 8;
  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int FIFO_DEPTH_DEF     = 4;

  // lane index width
  function automatic int idx_w(input int bpw);
    return $clog2(bpw);
  endfunction

  // lane count width, holds 0..bpw
  function automatic int cnt_w(input int bpw);
    return $clog2(bpw + 1);
  endfunction

  // fill level width, holds 0..depth
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dest_word_packer_word_fifo.sv
// Show-ahead FIFO of {count, word} entries with drop-on-full.
// Ports: clk/rst, push/din, pop, dout/valid (head), level, drop.
module word_fifo
  import dest_word_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                      drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

  // a pop in the same cycle frees the slot a full push needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign valid = !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dest_word_packer.sv
// Packs dest-domain byte strobes into words, buffers them in a FIFO.
// Ports: CLK/RST, in_data/in_valid, flush, out_* handshake, fifo_level, overflow.
module dest_word_packer
  import dest_word_packer_pkg::*;
#(
  parameter int DATAWIDTH      = DATAWIDTH_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [DATAWIDTH-1:0]                  in_data,
  input  logic                                  in_valid,
  input  logic                                  flush,
  output logic [DATAWIDTH*BYTES_PER_WORD-1:0]   out_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]   out_count,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level,
  output logic                                  overflow
);

  localparam int IDX_W  = idx_w(BYTES_PER_WORD);
  localparam int CNT_W  = cnt_w(BYTES_PER_WORD);
  localparam int LVL_W  = lvl_w(FIFO_DEPTH);
  localparam int WORD_W = DATAWIDTH * BYTES_PER_WORD;
  localparam int ENT_W  = CNT_W + WORD_W;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_d;
  logic [CNT_W-1:0]  post;
  logic              complete;
  logic              push;
  logic              drop;
  logic [ENT_W-1:0]  head;
  logic [LVL_W-1:0]  level;

  // word as it stands after this cycle's byte
  always_comb begin
    asm_d = asm_q;
    if (in_valid) asm_d[idx*DATAWIDTH +: DATAWIDTH] = in_data;
  end

  assign post     = CNT_W'(idx) + CNT_W'(in_valid);
  assign complete = in_valid && (idx == LAST);
  // a completing byte already pushes; flush then adds nothing
  assign push     = complete || (flush && (post != '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx   <= '0;
      asm_q <= '0;
    end else if (push) begin
      // cleared so a later partial word is zero-padded
      idx   <= '0;
      asm_q <= '0;
    end else if (in_valid) begin
      idx   <= idx + IDX_W'(1);
      asm_q <= asm_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  word_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   ({post, asm_d}),
    .pop   (out_ready),
    .dout  (head),
    .valid (out_valid),
    .level (level),
    .drop  (drop)
  );

  assign {out_count, out_data} = head;
  assign fifo_level            = level;

endmodule
